// File: rtl/trap_controller.sv
// Privilege/exception sequencer: owns Mode, redirects fetch to the trap vector and back on eret.
// Latency: event sampled at edge N -> trap_jump/flush/trap_PC visible during cycle N+1 (registered).
// Backpressure: stall=1 freezes event sampling in USER/KERNEL; ENTER/EXIT always complete in one cycle.
module trap_controller #(
  parameter logic [15:0] VECTOR       = 16'h0010,
  parameter logic [15:0] RESERVE_AREA = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Illegal_PC,
  input  logic        Illegal_Memory,
  input  logic [15:0] pc_fault_PC,
  input  logic [15:0] mem_fault_PC,
  input  logic        sys_call,
  input  logic        eret,
  input  logic        stall,
  input  logic        epc_we,
  input  logic [15:0] epc_wdata,
  output logic        Mode,
  output logic        trap_jump,
  output logic [15:0] trap_PC,
  output logic        flush,
  output logic [15:0] EPC,
  output logic [1:0]  cause,
  output logic [15:0] trap_count
);

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_KERNEL = 2'd2,
    ST_EXIT   = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_PRIV    = 2'b00;
  localparam logic [1:0] CAUSE_ILL_PC  = 2'b01;
  localparam logic [1:0] CAUSE_ILL_MEM = 2'b10;
  localparam logic [1:0] CAUSE_SYSCALL = 2'b11;

  state_t state;

  // Single FSM; every output is registered so the strobe cycle is the state cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_KERNEL;
      Mode       <= 1'b1;
      trap_jump  <= 1'b0;
      flush      <= 1'b0;
      trap_PC    <= 16'h0000;
      EPC        <= 16'h0000;
      cause      <= CAUSE_PRIV;
      trap_count <= 16'h0000;
    end else begin
      // Strobes default low; they are raised only on the edge entering ENTER/EXIT.
      trap_jump <= 1'b0;
      flush     <= 1'b0;
      case (state)
        ST_USER: begin
          if (!stall && (Illegal_Memory || Illegal_PC || sys_call || eret)) begin
            // Memory-stage fault belongs to the older instruction, so it wins.
            if (Illegal_Memory) begin
              EPC   <= mem_fault_PC;
              cause <= CAUSE_ILL_MEM;
            end else if (Illegal_PC) begin
              EPC   <= pc_fault_PC;
              cause <= CAUSE_ILL_PC;
            end else if (sys_call) begin
              // Resume after the syscall; 16-bit wrap is intended.
              EPC   <= pc_fault_PC + 16'd1;
              cause <= CAUSE_SYSCALL;
            end else begin
              EPC   <= pc_fault_PC;
              cause <= CAUSE_PRIV;
            end
            state      <= ST_ENTER;
            Mode       <= 1'b1;
            trap_jump  <= 1'b1;
            flush      <= 1'b1;
            trap_PC    <= VECTOR;
            trap_count <= trap_count + 16'd1;
          end
        end

        ST_ENTER: begin
          state <= ST_KERNEL;
        end

        ST_KERNEL: begin
          if (!stall) begin
            if (epc_we) begin
              EPC <= epc_wdata;
            end
            // Return target is judged on the EPC held before any same-cycle write;
            // a target inside the reserved area is refused so user code never runs there.
            if (eret && (EPC >= RESERVE_AREA)) begin
              state     <= ST_EXIT;
              trap_jump <= 1'b1;
              flush     <= 1'b1;
              trap_PC   <= EPC;
            end
          end
        end

        ST_EXIT: begin
          state <= ST_USER;
          Mode  <= 1'b0;
        end

        default: begin
          state <= ST_KERNEL;
          Mode  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: reset, round trip, priority, stalled syscall,
// refused return, same-cycle EPC write + eret, user eret, reset during ENTER.
module tb_trap_controller;

  logic        clk;
  logic        rst;
  logic        Illegal_PC;
  logic        Illegal_Memory;
  logic [15:0] pc_fault_PC;
  logic [15:0] mem_fault_PC;
  logic        sys_call;
  logic        eret;
  logic        stall;
  logic        epc_we;
  logic [15:0] epc_wdata;
  logic        Mode;
  logic        trap_jump;
  logic [15:0] trap_PC;
  logic        flush;
  logic [15:0] EPC;
  logic [1:0]  cause;
  logic [15:0] trap_count;

  int compared;
  int mismatched;

  trap_controller #(
    .VECTOR       (16'h0010),
    .RESERVE_AREA (16'h0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Illegal_PC     (Illegal_PC),
    .Illegal_Memory (Illegal_Memory),
    .pc_fault_PC    (pc_fault_PC),
    .mem_fault_PC   (mem_fault_PC),
    .sys_call       (sys_call),
    .eret           (eret),
    .stall          (stall),
    .epc_we         (epc_we),
    .epc_wdata      (epc_wdata),
    .Mode           (Mode),
    .trap_jump      (trap_jump),
    .trap_PC        (trap_PC),
    .flush          (flush),
    .EPC            (EPC),
    .cause          (cause),
    .trap_count     (trap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst            = 1'b1;
    Illegal_PC     = 1'b0;
    Illegal_Memory = 1'b0;
    pc_fault_PC    = 16'h0000;
    mem_fault_PC   = 16'h0000;
    sys_call       = 1'b0;
    eret           = 1'b0;
    stall          = 1'b0;
    epc_we         = 1'b0;
    epc_wdata      = 16'h0000;

    // Reset held for two cycles
    step();
    step();
    rst = 1'b0;
    check("rst_mode",  {15'd0, Mode},      16'h0001);
    check("rst_jump",  {15'd0, trap_jump}, 16'h0000);
    check("rst_flush", {15'd0, flush},     16'h0000);
    check("rst_tpc",   trap_PC,            16'h0000);
    check("rst_epc",   EPC,                16'h0000);
    check("rst_cause", {14'd0, cause},     16'h0000);
    check("rst_count", trap_count,         16'h0000);

    // Kernel writes EPC=0x0200 then returns
    epc_we = 1'b1; epc_wdata = 16'h0200;
    step();
    epc_we = 1'b0;
    check("kw_epc", EPC, 16'h0200);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("ret_jump",  {15'd0, trap_jump}, 16'h0001);
    check("ret_flush", {15'd0, flush},     16'h0001);
    check("ret_tpc",   trap_PC,            16'h0200);
    check("ret_mode1", {15'd0, Mode},      16'h0001);
    step();
    check("ret_jump_off", {15'd0, trap_jump}, 16'h0000);
    check("ret_mode0",    {15'd0, Mode},      16'h0000);

    // Illegal memory access in user mode
    Illegal_Memory = 1'b1; mem_fault_PC = 16'h0234;
    step();
    Illegal_Memory = 1'b0;
    check("im_jump",  {15'd0, trap_jump}, 16'h0001);
    check("im_flush", {15'd0, flush},     16'h0001);
    check("im_tpc",   trap_PC,            16'h0010);
    check("im_epc",   EPC,                16'h0234);
    check("im_cause", {14'd0, cause},     16'h0002);
    check("im_count", trap_count,         16'h0001);
    check("im_mode",  {15'd0, Mode},      16'h0001);
    step();
    check("im_kernel_jump", {15'd0, trap_jump}, 16'h0000);

    // Return to 0x0234
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("ret2_tpc", trap_PC, 16'h0234);
    step();
    check("ret2_mode", {15'd0, Mode}, 16'h0000);

    // Simultaneous illegal memory + illegal PC: memory wins, one trap
    Illegal_Memory = 1'b1; mem_fault_PC = 16'h0300;
    Illegal_PC     = 1'b1; pc_fault_PC  = 16'h0302;
    step();
    Illegal_Memory = 1'b0; Illegal_PC = 1'b0;
    check("sim_jump",  {15'd0, trap_jump}, 16'h0001);
    check("sim_cause", {14'd0, cause},     16'h0002);
    check("sim_epc",   EPC,                16'h0300);
    check("sim_count", trap_count,         16'h0002);
    step();
    check("sim_once_jump",  {15'd0, trap_jump}, 16'h0000);
    check("sim_once_count", trap_count,         16'h0002);

    // Return to 0x0300
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    check("ret3_mode", {15'd0, Mode}, 16'h0000);

    // Syscall at 0xFFFF held off by 3 stall cycles
    sys_call = 1'b1; pc_fault_PC = 16'hFFFF; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sc_stall_jump", {15'd0, trap_jump}, 16'h0000);
      check("sc_stall_mode", {15'd0, Mode},      16'h0000);
    end
    stall = 1'b0;
    step();
    sys_call = 1'b0;
    check("sc_jump",  {15'd0, trap_jump}, 16'h0001);
    check("sc_epc",   EPC,                16'h0000);
    check("sc_cause", {14'd0, cause},     16'h0003);
    check("sc_count", trap_count,         16'h0003);
    step();

    // Refused return: EPC inside reserved area
    epc_we = 1'b1; epc_wdata = 16'h00F0;
    step();
    epc_we = 1'b0;
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("bad_ret_jump", {15'd0, trap_jump}, 16'h0000);
    check("bad_ret_mode", {15'd0, Mode},      16'h0001);
    step();
    check("bad_ret_jump2", {15'd0, trap_jump}, 16'h0000);
    // Illegal_PC ignored in kernel
    Illegal_PC = 1'b1; pc_fault_PC = 16'h0400;
    step();
    Illegal_PC = 1'b0;
    check("kip_jump",  {15'd0, trap_jump}, 16'h0000);
    check("kip_epc",   EPC,                16'h00F0);
    check("kip_cause", {14'd0, cause},     16'h0003);
    check("kip_count", trap_count,         16'h0003);

    // Same-cycle write + eret, old EPC reserved -> refused, write lands
    epc_we = 1'b1; epc_wdata = 16'h0500; eret = 1'b1;
    step();
    check("we_er1_jump", {15'd0, trap_jump}, 16'h0000);
    check("we_er1_epc",  EPC,                16'h0500);
    // Same-cycle write + eret, old EPC legal -> returns to old, write lands
    epc_wdata = 16'h0050;
    step();
    epc_we = 1'b0; eret = 1'b0;
    check("we_er2_jump", {15'd0, trap_jump}, 16'h0001);
    check("we_er2_tpc",  trap_PC,            16'h0500);
    check("we_er2_epc",  EPC,                16'h0050);
    step();
    check("we_er2_mode", {15'd0, Mode}, 16'h0000);

    // epc_we ignored in user; eret in user is a privileged-instruction trap
    epc_we = 1'b1; epc_wdata = 16'h0777;
    step();
    epc_we = 1'b0;
    check("user_we_epc", EPC, 16'h0050);
    eret = 1'b1; pc_fault_PC = 16'h0123;
    step();
    eret = 1'b0;
    check("ueret_jump",  {15'd0, trap_jump}, 16'h0001);
    check("ueret_tpc",   trap_PC,            16'h0010);
    check("ueret_epc",   EPC,                16'h0123);
    check("ueret_cause", {14'd0, cause},     16'h0000);
    check("ueret_count", trap_count,         16'h0004);
    step();
    check("ueret_jump_off", {15'd0, trap_jump}, 16'h0000);

    // Reset during ENTER drops the redirect
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    check("pre_rst_mode", {15'd0, Mode}, 16'h0000);
    Illegal_PC = 1'b1; pc_fault_PC = 16'h0280;
    step();
    Illegal_PC = 1'b0;
    check("pre_rst_jump",  {15'd0, trap_jump}, 16'h0001);
    check("pre_rst_cause", {14'd0, cause},     16'h0001);
    check("pre_rst_count", trap_count,         16'h0005);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_jump",  {15'd0, trap_jump}, 16'h0000);
    check("mid_rst_flush", {15'd0, flush},     16'h0000);
    check("mid_rst_mode",  {15'd0, Mode},      16'h0001);
    check("mid_rst_count", trap_count,         16'h0000);
    check("mid_rst_epc",   EPC,                16'h0000);
    step();
    check("post_rst_jump", {15'd0, trap_jump}, 16'h0000);
    check("post_rst_mode", {15'd0, Mode},      16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
